alu_packet_deserializer: RTL and testbench

- Receive-side endpoint of the processor-to-ALU serial link: rebuilds a full ALU packet (op_2 | op_1 | op_code) from a bit-serial stream sent by the processor's transmitter.
- Hands the packet to the ALU datapath over a valid/ready handshake.
- Double-buffered: the next frame shifts in while the previous packet waits for the consumer.

---
 rtl/alu_packet_deserializer.sv | 148 ++++++++++++++
 tb/tb_alu_packet_deserializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_packet_deserializer.sv
// Purpose : rebuilds an ALU packet {op_2, op_1, op_code} from the processor's LSB-first serial link.
// Latency : out_valid rises the cycle after the last frame bit is sampled (the parity bit when parity is enabled).
// Backpr. : double-buffered; a completed frame that finds the output buffer full is dropped and flagged.
//
// Optional feature: define ALU_PACKET_PARITY_EN to require one trailing even-parity bit per frame.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   rx_start/rx_valid/rx_bit  serial input; rx_start marks bit 0 of a frame
//   out_packet/out_op_code  assembled packet and its opcode field
//   out_valid/out_ready     valid/ready handshake towards the ALU datapath
//   busy                    a frame is being received
//   overrun                 sticky: a finished frame was dropped because the buffer was full
//   frame_error             one-cycle pulse on abort, drop or parity failure
module alu_packet_deserializer #(
  parameter int REGISTER_SIZE = 32,
  parameter int OPCODE_WIDTH  = 3,
  parameter int PACKET_WIDTH  = 2 * REGISTER_SIZE + OPCODE_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rx_start,
  input  logic                    rx_valid,
  input  logic                    rx_bit,
  output logic [PACKET_WIDTH-1:0] out_packet,
  output logic [OPCODE_WIDTH-1:0] out_op_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_error
);

  localparam int CNT_W = $clog2(PACKET_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PACKET_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]        count;

  logic                    start_ev;
  logic                    store_bit;
  logic                    last_bit;
  logic                    abort;
  logic                    commit_req;
  logic                    parity_bad;
  logic [PACKET_WIDTH-1:0] commit_data;
  logic                    can_take;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_valid && rx_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (rx_valid && !rx_start && last_bit) begin
`ifdef ALU_PACKET_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
`endif
        end
      end
      PARITY: begin
        // A start bit here restarts the frame; any other valid bit is the parity bit.
        if (rx_valid && rx_start)      state_nxt = SHIFT;
        else if (rx_valid)             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy        = (state != IDLE);
    start_ev    = rx_valid && rx_start;
    store_bit   = (state == SHIFT) && rx_valid && !rx_start;
    last_bit    = (count == LAST_IDX);
    abort       = start_ev && (state != IDLE);
    commit_data = shift_reg;
`ifdef ALU_PACKET_PARITY_EN
    // Even parity over payload plus the parity bit: XOR of everything must be 0.
    commit_req  = (state == PARITY) && rx_valid && !rx_start && !((^shift_reg) ^ rx_bit);
    parity_bad  = (state == PARITY) && rx_valid && !rx_start &&  ((^shift_reg) ^ rx_bit);
`else
    // Commit in the same cycle the last bit arrives, so splice that bit in directly.
    commit_req  = store_bit && last_bit;
    parity_bad  = 1'b0;
    commit_data[PACKET_WIDTH-1] = rx_bit;
`endif
    // The output slot is free if empty or being drained this very cycle.
    can_take    = !out_valid || out_ready;
  end

  // Receive shift register and bit counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      count     <= '0;
    end else if (start_ev) begin
      shift_reg[0] <= rx_bit;
      count        <= CNT_W'(1);
    end else if (store_bit) begin
      shift_reg[count] <= rx_bit;
      count            <= last_bit ? '0 : count + CNT_W'(1);
    end
  end

  // Output buffer and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_packet  <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (commit_req && can_take) begin
        out_packet <= commit_data;
        out_valid  <= 1'b1;
      end else begin
        if (commit_req) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
      frame_error <= abort || (commit_req && !can_take) || parity_bad;
    end
  end

  assign out_op_code = out_packet[OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_alu_packet_deserializer.sv
module tb_alu_packet_deserializer;
  localparam int RS = 32;
  localparam int OW = 3;
  localparam int PW = 2 * RS + OW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          rx_start;
  logic          rx_valid;
  logic          rx_bit;
  logic [PW-1:0] out_packet;
  logic [OW-1:0] out_op_code;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;
  logic          frame_error;

  int n_cmp = 0;
  int n_err = 0;
  int fe_count = 0;

  alu_packet_deserializer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_start    (rx_start),
    .rx_valid    (rx_valid),
    .rx_bit      (rx_bit),
    .out_packet  (out_packet),
    .out_op_code (out_op_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  // Counts cycles with frame_error high (so a count of 1 also means a single-cycle pulse).
  always @(negedge clock) if (frame_error === 1'b1) fe_count++;

  function automatic logic [PW-1:0] mk(input logic [OW-1:0] op, input logic [RS-1:0] a, input logic [RS-1:0] b);
    return {b, a, op};
  endfunction

  // Inputs change on the falling edge; the DUT samples on the following rising edge.
  task automatic drive(input logic v, input logic s, input logic b);
    @(negedge clock);
    rx_valid = v;
    rx_start = s;
    rx_bit   = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [PW-1:0] p, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, (i == 0), p[i]);
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic flip_par);
    send_bits(p, PW);
`ifdef ALU_PACKET_PARITY_EN
    drive(1'b1, 1'b0, (^p) ^ flip_par);
`else
    if (flip_par) $display("note: parity flip ignored in this build");
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx_start = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (out_packet !== '0) begin n_err++; $display("FAIL reset_packet: got %h want 0", out_packet); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    reset_n = 1'b1;
    idle(); idle();
  endtask

  task automatic test_add();
    logic [PW-1:0] exp;
    exp = {32'h3, 32'h5, 3'h0};
    out_ready = 1'b1;
    send_frame(mk(3'd0, 32'h5, 32'h3), 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
    idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_packet !== exp) begin n_err++; $display("FAIL add_packet: got %h want %h", out_packet, exp); end
    n_cmp++; if (out_op_code !== 3'd0) begin n_err++; $display("FAIL add_opcode: got %h want 0", out_op_code); end
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_stalled();
    logic [PW-1:0] exp;
    int busy_bad;
    exp = mk(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    busy_bad = 0;
    fe_count = 0;
    out_ready = 1'b1;
    for (int i = 0; i < PW; i++) begin
      drive(1'b1, (i == 0), exp[i]);
      if (i < PW - 1) begin
        idle();
        if (busy !== 1'b1) busy_bad++;
      end
    end
`ifdef ALU_PACKET_PARITY_EN
    idle();
    if (busy !== 1'b1) busy_bad++;
    drive(1'b1, 1'b0, ^exp);
`endif
    idle();
    n_cmp++; if (busy_bad != 0) begin n_err++; $display("FAIL stall_busy: got %0d low cycles want 0", busy_bad); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_busy_end: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_packet !== exp) begin n_err++; $display("FAIL stall_packet: got %h want %h", out_packet, exp); end
    n_cmp++; if (out_op_code !== 3'd2) begin n_err++; $display("FAIL stall_opcode: got %h want 2", out_op_code); end
    idle();
    n_cmp++; if (fe_count != 0) begin n_err++; $display("FAIL stall_frame_error: got %0d want 0", fe_count); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    x = mk(3'd1, 32'h0000_0010, 32'h0000_0001);
    y = mk(3'd5, 32'hAAAA_5555, 32'h0123_4567);
    fe_count = 0;
    out_ready = 1'b1;
    send_frame(x, 1'b0);
    drive(1'b1, 1'b1, y[0]);
    n_cmp++; if (out_valid !== 1'b1 || out_packet !== x) begin n_err++; $display("FAIL b2b_first: got v=%b %h want v=1 %h", out_valid, out_packet, x); end
    for (int i = 1; i < PW; i++) drive(1'b1, 1'b0, y[i]);
`ifdef ALU_PACKET_PARITY_EN
    drive(1'b1, 1'b0, ^y);
`endif
    idle();
    n_cmp++; if (out_valid !== 1'b1 || out_packet !== y) begin n_err++; $display("FAIL b2b_second: got v=%b %h want v=1 %h", out_valid, out_packet, y); end
    idle();
    n_cmp++; if (fe_count != 0) begin n_err++; $display("FAIL b2b_frame_error: got %0d want 0", fe_count); end
  endtask

  task automatic test_overrun();
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    a = mk(3'd6, 32'h8000_0001, 32'h0000_0004);
    b = mk(3'd3, 32'h0F0F_0F0F, 32'hFF00_FF00);
    fe_count = 0;
    out_ready = 1'b0;
    send_frame(a, 1'b0);
    send_frame(b, 1'b0);
    idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_packet !== a) begin n_err++; $display("FAIL ovr_held: got %h want %h", out_packet, a); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    idle();
    n_cmp++; if (fe_count != 1) begin n_err++; $display("FAIL ovr_frame_error: got %0d want 1", fe_count); end
    n_cmp++; if (out_packet !== a) begin n_err++; $display("FAIL ovr_stable: got %h want %h", out_packet, a); end
    out_ready = 1'b1;
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
    idle(); idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_no_second: got %b want 0", out_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_abort();
    logic [PW-1:0] sw;
    sw = mk(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    fe_count = 0;
    out_ready = 1'b1;
    send_bits(mk(3'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D), 20);
    send_frame(sw, 1'b0);
    idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL abort_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_packet !== sw) begin n_err++; $display("FAIL abort_packet: got %h want %h", out_packet, sw); end
    idle();
    n_cmp++; if (fe_count != 1) begin n_err++; $display("FAIL abort_frame_error: got %0d want 1", fe_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_single: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] orp;
    orp = mk(3'd4, 32'h0000_000A, 32'h0000_0005);
    out_ready = 1'b1;
    send_bits(mk(3'd2, 32'h1111_2222, 32'h3333_4444), 40);
    @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstm_busy_before: got %b want 1", busy); end
    rx_valid = 1'b0; rx_start = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_packet !== '0 || out_op_code !== '0) begin n_err++; $display("FAIL rstm_packet: got %h/%h want 0", out_packet, out_op_code); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstm_valid_busy: got %b/%b want 0/0", out_valid, busy); end
    n_cmp++; if (overrun !== 1'b0 || frame_error !== 1'b0) begin n_err++; $display("FAIL rstm_flags: got %b/%b want 0/0", overrun, frame_error); end
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    send_frame(orp, 1'b0);
    idle();
    n_cmp++; if (out_valid !== 1'b1 || out_packet !== orp) begin n_err++; $display("FAIL rstm_or: got v=%b %h want v=1 %h", out_valid, out_packet, orp); end
    idle();
  endtask

`ifdef ALU_PACKET_PARITY_EN
  task automatic test_parity();
    logic [PW-1:0] p;
    p = mk(3'd0, 32'h5, 32'h3);
    fe_count = 0;
    out_ready = 1'b1;
    send_frame(p, 1'b1);
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL par_bad_valid: got %b want 0", out_valid); end
    idle();
    n_cmp++; if (fe_count != 1) begin n_err++; $display("FAIL par_bad_frame_error: got %0d want 1", fe_count); end
    send_frame(p, 1'b0);
    idle();
    n_cmp++; if (out_valid !== 1'b1 || out_packet !== p) begin n_err++; $display("FAIL par_good: got v=%b %h want v=1 %h", out_valid, out_packet, p); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_stalled();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid();
`ifdef ALU_PACKET_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
